// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cnt_pkg
//  Shared definitions for the counter/timer blocks: FSM state encoding.
//  Revision: 1.0 - initial release
// ============================================================================
package cnt_pkg;

   // Encoding 2'd3 is unused; the timer FSM treats it as illegal and
   // recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cnt_state_t;

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/dn_cnt_core.sv
`default_nettype none
// ============================================================================
//  Module : dn_cnt_core
//  WIDTH-bit down-count register with load / decrement / hold and an
//  "equals one" compare used by the timer to detect terminal count.
//  Ports:
//     clk      in   1      clock
//     rst_n    in   1      asynchronous active-low reset (clears count)
//     ld       in   1      load ld_data (priority over dec)
//     ld_data  in   WIDTH  value to load
//     dec      in   1      decrement request (ignored when count is 0)
//     q        out  WIDTH  current count (registered)
//     is_one   out  1      q == 1
//  Revision: 1.0 - initial release
// ============================================================================
module dn_cnt_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             dec,
   output logic [WIDTH-1:0] q,
   output logic             is_one
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= ld_data;
      end else if (dec && (r_q != '0)) begin
         // Guard keeps the count from wrapping below zero.
         r_q <= r_q - WIDTH'(1);
      end
   end

   assign q      = r_q;
   assign is_one = (r_q == WIDTH'(1));

endmodule : dn_cnt_core
`default_nettype wire

// File: rtl/down_cnt_timer.sv
`default_nettype none
// ============================================================================
//  Module : down_cnt_timer
//  Loadable down-counter/timer with one-shot or auto-reload operation.
//  Ports:
//     clk      in   1      clock, all state updates on posedge
//     rst_n    in   1      asynchronous active-low reset
//     load     in   1      load strobe, highest synchronous priority
//     ld_val   in   WIDTH  start/reload value, sampled when load=1
//     en       in   1      count enable (effective only in RUN)
//     reload   in   1      1 = reload at terminal count, 0 = one-shot
//     q        out  WIDTH  current count
//     tc       out  1      terminal-count pulse, one cycle wide
//     busy     out  1      state == RUN
//     exp      out  1      state == DONE (sticky until next load)
//  Revision: 1.0 - initial release
// ============================================================================
module down_cnt_timer
   import cnt_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             en,
   input  logic             reload,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             exp
);

   cnt_state_t       r_state;
   cnt_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_rld;
   logic             r_tc;

   logic             w_run;
   logic             w_is_one;
   logic             w_term;
   logic             w_ld;
   logic [WIDTH-1:0] w_ld_data;
   logic             w_dec;
   logic [WIDTH-1:0] w_q;

   assign w_run  = (r_state == ST_RUN);
   // Terminal edge: an enabled count from 1. A coincident load pre-empts it,
   // which also suppresses the tc pulse and the reload.
   assign w_term = w_run & en & w_is_one & ~load;

   assign w_ld      = load | (w_term & reload);
   assign w_ld_data = load ? ld_val : r_rld;
   assign w_dec     = w_run & en & ~load;

   dn_cnt_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (w_ld),
      .ld_data (w_ld_data),
      .dec     (w_dec),
      .q       (w_q),
      .is_one  (w_is_one)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (load) begin
         // A zero start value has nothing to count; park in IDLE.
         w_state_nxt = (ld_val != '0) ? ST_RUN : ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_RUN:  w_state_nxt = (w_term && !reload) ? ST_DONE : ST_RUN;
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // --------------------------------------------- reload value and tc flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rld <= '0;
         r_tc  <= 1'b0;
      end else begin
         if (load) begin
            r_rld <= ld_val;
         end
         r_tc <= w_term;
      end
   end

   assign q    = w_q;
   assign tc   = r_tc;
   assign busy = (r_state == ST_RUN);
   assign exp  = (r_state == ST_DONE);

endmodule : down_cnt_timer
`default_nettype wire

// File: tb/tb_down_cnt_timer.sv
`default_nettype none
// ============================================================================
//  Module : tb_down_cnt_timer
//  Self-checking bench for down_cnt_timer: directed scenarios with literal
//  expectations plus randomized traffic against a behavioural model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_down_cnt_timer;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             load;
   logic [WIDTH-1:0] ld_val;
   logic             en;
   logic             reload;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             exp;

   int n_checks = 0;
   int n_fail   = 0;

   down_cnt_timer #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .ld_val (ld_val),
      .en     (en),
      .reload (reload),
      .q      (q),
      .tc     (tc),
      .busy   (busy),
      .exp    (exp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------ behavioural model
   // mode: 0 = idle, 1 = running, 2 = expired
   int m_q    = 0;
   int m_rld  = 0;
   int m_mode = 0;
   int m_tc   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = 0; m_rld = 0; m_mode = 0; m_tc = 0;
      end else if (load) begin
         m_q    = int'(ld_val);
         m_rld  = int'(ld_val);
         m_tc   = 0;
         m_mode = (ld_val != 0) ? 1 : 0;
      end else begin
         m_tc = 0;
         if (m_mode == 1 && en) begin
            if (m_q == 1) begin
               m_tc = 1;
               if (reload) begin
                  m_q = m_rld;
               end else begin
                  m_q    = 0;
                  m_mode = 2;
               end
            end else if (m_q > 1) begin
               m_q = m_q - 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("model_q",    int'(q),    m_q);
      chk("model_tc",   int'(tc),   m_tc);
      chk("model_busy", int'(busy), (m_mode == 1) ? 1 : 0);
      chk("model_exp",  int'(exp),  (m_mode == 2) ? 1 : 0);
   end

   // One clock edge, then settle inputs can be changed / outputs sampled.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_load(input int v);
      load   = 1'b1;
      ld_val = WIDTH'(v);
      step();
      load   = 1'b0;
   endtask

   initial begin
      int cnt;
      rst_n  = 1'b0;
      load   = 1'b0;
      ld_val = '0;
      en     = 1'b0;
      reload = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("reset_q", int'(q), 0);
      chk("reset_busy", int'(busy), 0);

      // One-shot from 3.
      en = 1'b1; reload = 1'b0;
      do_load(3);
      chk("os_q_load", int'(q), 3);
      chk("os_busy", int'(busy), 1);
      step(); chk("os_q2", int'(q), 2);
      step(); chk("os_q1", int'(q), 1); chk("os_tc_pre", int'(tc), 0);
      step(); chk("os_q0", int'(q), 0); chk("os_tc", int'(tc), 1);
      chk("os_exp", int'(exp), 1); chk("os_busy_after", int'(busy), 0);
      step(); chk("os_tc_clear", int'(tc), 0); chk("os_exp_hold", int'(exp), 1);
      chk("os_q_hold", int'(q), 0);

      // Auto-reload from 4 for 12 enabled cycles.
      reload = 1'b1;
      do_load(4);
      chk("ar_q_load", int'(q), 4);
      chk("ar_exp_cleared", int'(exp), 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("ar_q", int'(q), (k % 4 == 0) ? 4 : 4 - (k % 4));
         chk("ar_tc", int'(tc), (k % 4 == 0) ? 1 : 0);
      end

      // Enable gating from 5.
      reload = 1'b0;
      do_load(5);
      en = 1'b1; step(); chk("eg_q4", int'(q), 4);
      en = 1'b0; step(); chk("eg_q4h", int'(q), 4);
      en = 1'b1; step(); chk("eg_q3", int'(q), 3);
      en = 1'b0; step(); chk("eg_q3h", int'(q), 3);
      chk("eg_tc", int'(tc), 0); chk("eg_busy", int'(busy), 1);

      // Load of zero parks in idle.
      en = 1'b1;
      do_load(0);
      chk("z_q", int'(q), 0); chk("z_busy", int'(busy), 0);
      chk("z_exp", int'(exp), 0);
      step(); chk("z_tc", int'(tc), 0); chk("z_q_hold", int'(q), 0);

      // Load coincident with terminal edge.
      reload = 1'b1;
      do_load(2);
      step(); chk("lt_q1", int'(q), 1);
      do_load(7);
      chk("lt_q7", int'(q), 7); chk("lt_tc", int'(tc), 0);
      chk("lt_busy", int'(busy), 1);

      // Full-scale one-shot: 15 enabled cycles to terminal count.
      reload = 1'b0; en = 1'b1;
      do_load(15);
      cnt = 0;
      while (tc !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
      chk("max_cycles_to_tc", cnt, 15);

      // Asynchronous reset mid-count, checked without a clock edge.
      do_load(15);
      for (int k = 0; k < 7; k++) step();
      chk("ar8_q", int'(q), 8);
      #1 rst_n = 1'b0;
      #1;
      chk("async_q", int'(q), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_tc", int'(tc), 0);
      chk("async_exp", int'(exp), 0);
      step();
      rst_n = 1'b1;

      // Randomized traffic; small load values exercise divide-by-1/2 reload.
      for (int i = 0; i < 3000; i++) begin
         load   = ($urandom_range(0, 9) == 0);
         ld_val = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 3))
                                              : WIDTH'($urandom);
         en     = ($urandom_range(0, 3) != 0);
         reload = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_down_cnt_timer
`default_nettype wire
